// File: rtl/alu_pkg.sv
// Shared opcode map and FSM state encoding for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_NOT = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } alu_state_t;

endpackage

// File: rtl/alu_shift_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, H cycles per product.
module alu_shift_mul #(
  parameter int H = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [H-1:0]   a,
  input  logic [H-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*H-1:0] product
);

  localparam int CW = (H > 1) ? $clog2(H) : 1;

  logic [2*H-1:0] r_mcand;
  logic [H-1:0]   r_mplier;
  logic [2*H-1:0] r_accum;
  logic [CW-1:0]  r_count;
  logic           r_busy;
  logic [2*H-1:0] w_partial;
  logic [2*H-1:0] w_accumNext;

  // product reflects the step being taken this cycle, so the owner can capture it on the final step
  assign w_partial   = r_mplier[0] ? r_mcand : '0;
  assign w_accumNext = r_accum + w_partial;
  assign product     = w_accumNext;
  assign busy        = r_busy;
  assign done        = r_busy && (r_count == CW'(H - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_accum  <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_mcand  <= {{H{1'b0}}, a};
      r_mplier <= b;
      r_accum  <= '0;
      r_count  <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_accum  <= w_accumNext;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 1'b1;
      if (done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential WIDTH-bit ALU with valid/ready handshakes, registered result and status flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int H = WIDTH / 2;

  alu_state_t       r_state;
  alu_state_t       w_nextState;
  logic [WIDTH-1:0] r_result;
  logic             r_z, r_n, r_c, r_v;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_load;
  logic [WIDTH-1:0] w_result;
  logic             w_c, w_v;
  logic             w_mulStart;
  logic             w_mulBusy;
  logic             w_mulDone;
  logic [WIDTH-1:0] w_mulProduct;

  alu_shift_mul #(.H(H)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_mulStart),
    .a       (a[H-1:0]),
    .b       (b[H-1:0]),
    .busy    (w_mulBusy),
    .done    (w_mulDone),
    .product (w_mulProduct)
  );

  // The extra top bit of the difference is the unsigned borrow
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_result    = '0;
    w_c         = 1'b0;
    w_v         = 1'b0;
    w_mulStart  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          if (opcode == OP_MUL) begin
            w_mulStart  = 1'b1;
            w_nextState = ST_MUL;
          end else begin
            w_load      = 1'b1;
            w_nextState = ST_DONE;
            case (opcode)
              OP_NOT: w_result = ~a;
              OP_OR:  w_result = a | b;
              OP_XOR: w_result = a ^ b;
              OP_AND: w_result = a & b;
              OP_ADD: begin
                w_result = w_sum[WIDTH-1:0];
                w_c      = w_sum[WIDTH];
                w_v      = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
              end
              OP_SUB: begin
                w_result = w_diff[WIDTH-1:0];
                w_c      = w_diff[WIDTH];
                w_v      = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
              end
              default: w_result = '0;
            endcase
          end
        end
      end
      ST_MUL: begin
        if (w_mulDone) begin
          w_load      = 1'b1;
          w_result    = w_mulProduct;
          w_nextState = ST_DONE;
        end else if (!w_mulBusy) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (out_ready) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_load) begin
        r_result <= w_result;
        r_z      <= (w_result == '0);
        r_n      <= w_result[WIDTH-1];
        r_c      <= w_c;
        r_v      <= w_v;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign flag_z    = r_z;
  assign flag_n    = r_n;
  assign flag_c    = r_c;
  assign flag_v    = r_v;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8) with an arithmetic reference model and scoreboard.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       flag_z, flag_n, flag_c, flag_v;

  typedef struct {
    logic [7:0] r;
    logic       z, n, c, v;
  } exp_t;

  exp_t expQ[$];
  int   nAsserts = 0;
  int   nFails   = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic exp_t model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int ua, ub, sa, sb, full, sres;
    ua = int'(x);
    ub = int'(y);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    e.c = 1'b0;
    e.v = 1'b0;
    full = 0;
    case (op)
      3'd0: full = 255 - ua;
      3'd1: full = int'(x | y);
      3'd2: full = int'(x ^ y);
      3'd3: full = int'(x & y);
      3'd4: full = (ua % 16) * (ub % 16);
      3'd5: begin
        full = ua + ub;
        sres = sa + sb;
        e.c  = (full > 255);
        e.v  = (sres > 127) || (sres < -128);
      end
      3'd6: begin
        full = ua - ub;
        sres = sa - sb;
        e.c  = (ua < ub);
        e.v  = (sres > 127) || (sres < -128);
      end
      default: full = 0;
    endcase
    e.r = full[7:0];
    e.z = (e.r == 8'h00);
    e.n = e.r[7];
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAsserts++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] r,
                             input logic z, input logic n, input logic c, input logic v);
    check({name, ".result"}, 32'(result), 32'(r));
    check({name, ".z"}, 32'(flag_z), 32'(z));
    check({name, ".n"}, 32'(flag_n), 32'(n));
    check({name, ".c"}, 32'(flag_c), 32'(c));
    check({name, ".v"}, 32'(flag_v), 32'(v));
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accept edge
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] ia, input logic [7:0] ib);
    in_valid = 1'b1;
    opcode   = op;
    a        = ia;
    b        = ib;
    expQ.push_back(model(op, ia, ib));
    @(negedge clk);
    check("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 8'($urandom);
    b        = 8'($urandom);
    opcode   = 3'($urandom);
  endtask

  task automatic waitValid(input string name, input int expLat, input bit checkBusy);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (out_valid) seen = 1'b1;
      else if (checkBusy) check({name, ".busy_in_ready"}, 32'(in_ready), 32'd0);
    end
    check({name, ".latency"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(expLat));
  endtask

  task automatic drain(input string name);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({name, ".drain_in_ready"}, 32'(in_ready), 32'd1);
    check({name, ".drain_out_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every valid output cycle must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        check("sb.spurious_valid", 32'd1, 32'd0);
      end else begin
        check("sb.result", 32'(result), 32'(expQ[0].r));
        check("sb.flags", {28'd0, flag_z, flag_n, flag_c, flag_v},
              {28'd0, expQ[0].z, expQ[0].n, expQ[0].c, expQ[0].v});
        if (out_ready) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [7:0] sweepRes [8];
  logic [3:0] sweepFlg [8];

  initial begin
    sweepRes = '{8'h3C, 8'hDB, 8'h99, 8'h42, 8'h1E, 8'h1D, 8'h69, 8'h00};
    sweepFlg = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0010, 4'b0001, 4'b1000};

    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    a         = 8'h12;
    b         = 8'h34;
    opcode    = 3'b101;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Reset in the middle of a multiply
    applyStimulus(3'b100, 8'h0F, 8'h0F);
    @(posedge clk);
    #1;
    rst = 1'b1;
    expQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midmul.out_valid", 32'(out_valid), 32'd0);
      check("midmul.in_ready", 32'(in_ready), 32'd1);
    end
    check("midmul.result", 32'(result), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(3'b100, 8'h0F, 8'h0F);
    waitValid("mul_after_reset", 5, 1'b1);
    checkOutput("mul_after_reset", 8'hE1, 1'b0, 1'b1, 1'b0, 1'b0);
    drain("mul_after_reset");

    applyStimulus(3'b101, 8'h7F, 8'h01);
    waitValid("add_ovf", 1, 1'b0);
    checkOutput("add_ovf", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    drain("add_ovf");

    applyStimulus(3'b110, 8'h00, 8'h01);
    waitValid("sub_borrow", 1, 1'b0);
    checkOutput("sub_borrow", 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
    drain("sub_borrow");

    applyStimulus(3'b110, 8'h80, 8'h01);
    waitValid("sub_ovf", 1, 1'b0);
    checkOutput("sub_ovf", 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
    drain("sub_ovf");

    applyStimulus(3'b100, 8'hAF, 8'h3E);
    waitValid("mul_nibbles", 5, 1'b1);
    checkOutput("mul_nibbles", 8'hD2, 1'b0, 1'b1, 1'b0, 1'b0);
    drain("mul_nibbles");

    // Back-pressure: result must hold while the sink stalls
    applyStimulus(3'b000, 8'h00, 8'h55);
    waitValid("not_bp", 1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp.out_valid", 32'(out_valid), 32'd1);
      check("bp.in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp", 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    drain("not_bp");

    for (int op = 0; op < 8; op++) begin
      applyStimulus(3'(op), 8'hC3, 8'h5A);
      waitValid("sweep", (op == 4) ? 5 : 1, 1'b0);
      checkOutput("sweep", sweepRes[op], sweepFlg[op][3], sweepFlg[op][2],
                  sweepFlg[op][1], sweepFlg[op][0]);
      drain("sweep");
    end

    check("sb.queue_empty", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
